svc_rv_ifetch: RTL and testbench
================================

// Module: svc_rv_ifetch
//
// PURPOSE
// Instruction-fetch initiator for the svc_rv core; drives the imem_arvalid/araddr request side and consumes imem_rdata/rvalid.
// Keeps a sequential PC, limits outstanding reads by credit and buffers responses in a small in-order FIFO.
// Hands {pc, insn} to decode over a valid/ready handshake. Squashes stale fetches on a redirect (branch, jump or trap).
//
// PARAMETERS
// XLEN          32   address/data width (PC, araddr, rdata, inst_data)
// RESET_PC      0    first fetch address after reset; bits [1:0] must be 0
// IMEM_LATENCY  1    0: rvalid/rdata same cycle as arvalid; 1: exactly one cycle later
// DEPTH         2    FIFO entries (power of 2, >=2); also bounds in-flight + buffered fetches
//
// PORTS
// clock           in   1     core clock, all state on rising edge
// reset           in   1     synchronous, active-high
// redirect_valid  in   1     flush and restart fetch at redirect_pc
// redirect_pc     in   XLEN  new fetch PC; bits [1:0] ignored (forced 0)
// imem_arvalid    out  1     read request this cycle
// imem_araddr     out  XLEN  word-aligned request address
// imem_rdata      in   32    instruction word, qualified by imem_rvalid
// imem_rvalid     in   1     response valid, in request order
// inst_valid      out  1     FIFO head valid to decode
// inst_ready      in   1     decode accepts head
// inst_pc         out  XLEN  PC of head instruction
// inst_data       out  32    head instruction word
//
// BEHAVIOUR
// - Reset: fetch_pc=RESET_PC; FIFO empty; in-flight=0; imem_arvalid=0; inst_valid=0; araddr=RESET_PC.
// - pop = inst_valid & inst_ready. Head leaves the FIFO on the following edge.
// - Credit: issue = !reset & !redirect_valid & (count + inflight - pop < DEPTH). The ready->arvalid combinational path is intended.
// - imem_arvalid=issue; imem_araddr=fetch_pc. On issue, fetch_pc <= fetch_pc+4, wrapping mod 2^XLEN. The issued PC is tagged in an in-flight PC register (LATENCY=1) or bypassed straight through (LATENCY=0).
// - Response: imem_rvalid with inflight>0 pushes {tag_pc, imem_rdata} into the FIFO. Credit guarantees the FIFO is never full at push, so no overflow check is needed.
// - Push and pop may occur in the same cycle; count is unchanged in that case. Push into an empty FIFO is visible on inst_valid the next cycle, with no bypass.
// - imem_rvalid with inflight==0 is ignored. This covers spurious or post-reset responses.
// - Redirect (highest priority below reset), in the same cycle:
//   - arvalid=0.
//   - FIFO flushed; count <= 0. inst_valid may still be 1 during the redirect cycle, but the head is discarded even if popped. Decode owns squash of that cycle.
//   - Every in-flight response is discarded: a drop counter is loaded with inflight.
//   - fetch_pc <= {redirect_pc[XLEN-1:2],2'b00}.
//   - First new request issues the next cycle.
// - Drop counter: each rvalid while drop>0 decrements it and is not pushed. Credit treats dropped-pending reads as in-flight.
// - Back-to-back redirects: each redirect restarts fetch. Drop counts accumulate correctly because no new issue occurs on a redirect cycle.
// - Steady state with inst_ready=1, LATENCY=1, DEPTH=2: one instruction per cycle after a 2-cycle startup.
// - inst_ready low: at most DEPTH instructions buffered or in flight, then arvalid=0 until a pop.
// - Reset asserted mid-operation: state is returned to reset values on that edge, and in-flight responses are dropped via the inflight==0 rule.
//
// TESTING
// - Reset release, RESET_PC=0x100, inst_ready=1, LATENCY=1: araddr 0x100,0x104,0x108 on consecutive cycles. inst_pc 0x100 is presented 2 cycles after the first arvalid, then one per cycle.
// - Backpressure: inst_ready=0 from start, DEPTH=2: exactly 2 requests issued, arvalid then 0. Raise ready for 1 cycle: one pop, one new request the same cycle.
// - Redirect while 1 in flight and FIFO holding 0x104: redirect_pc=0x203. No arvalid that cycle; the stale response is dropped; next araddr=0x200; first inst_pc=0x200.
// - Redirect on two consecutive cycles (0x300 then 0x400): only 0x400-stream instructions are ever delivered.
// - PC wrap: redirect to 0xFFFFFFFC: fetch 0xFFFFFFFC then 0x00000000, with inst_pc values matching.
// - LATENCY=0, spurious imem_rvalid after reset with no request: no inst_valid; mid-stream reset clears inst_valid on the next cycle.

Source files
------------

// File: rtl/svc_rv_ifetch.sv
// svc_rv_ifetch: instruction-fetch initiator for the svc_rv core.
// Issues sequential word fetches under a credit limit and buffers responses
// in an in-order FIFO. Decode receives {pc, insn} over a valid/ready handshake.
// Redirects flush the FIFO and squash every read still in flight.
module svc_rv_ifetch #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter int              IMEM_LATENCY = 1,
  parameter int              DEPTH        = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_arvalid,
  output logic [XLEN-1:0] imem_araddr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_rvalid,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_pc,
  output logic [31:0]     inst_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] tag_pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   count;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [31:0]     data_mem [DEPTH];
  logic [CW:0]     occupancy;
  logic            pop;
  logic            issue;
  logic            accept;
  logic            push;
  logic            unused_pc_lsbs;

  // The low redirect bits are discarded when the PC is word-aligned.
  assign unused_pc_lsbs = ^redirect_pc[1:0];

  // Handshake, credit and response-acceptance decisions for this cycle.
  // inflight counts every outstanding read, including those already marked
  // for dropping, so credit and the drop reload both come from it directly.
  always_comb begin
    inst_valid = (count != '0);
    pop        = inst_valid && inst_ready;
    // Includes the head leaving this cycle, so inst_ready feeds arvalid.
    occupancy  = {1'b0, count} + {1'b0, inflight} - (CW + 1)'(pop);
    issue      = !reset && !redirect_valid && (occupancy < (CW + 1)'(DEPTH));
    // With zero latency the read issued this cycle answers in the same cycle.
    accept     = imem_rvalid && ((inflight != '0) || ((IMEM_LATENCY == 0) && issue));
    resp_pc    = (inflight != '0) ? tag_pc : fetch_pc;
    push       = accept && (drop == '0) && !redirect_valid && !reset;
  end

  assign imem_arvalid = issue;
  assign imem_araddr  = fetch_pc;
  assign inst_pc      = pc_mem[rd_ptr];
  assign inst_data    = data_mem[rd_ptr];

  // Fetch PC, outstanding-read bookkeeping and FIFO pointers.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      tag_pc   <= RESET_PC;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      inflight <= inflight + CW'(issue) - CW'(accept);
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        drop     <= inflight - CW'(accept);
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (accept && (drop != '0)) begin
          drop <= drop - CW'(1);
        end
        if (issue) begin
          fetch_pc <= fetch_pc + XLEN'(4);
          tag_pc   <= fetch_pc;
        end
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // FIFO storage; contents are don't-care while the slot is not counted.
  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem[wr_ptr]   <= resp_pc;
      data_mem[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_svc_rv_ifetch.sv
// Scoreboard bench for svc_rv_ifetch: a one-cycle-latency instance with
// RESET_PC=0x100 and a zero-latency instance with RESET_PC=0.
module tb_svc_rv_ifetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } item_t;

  logic        clock;
  // latency-1 instance
  logic        reset1, redirect1, ready1, spur1;
  logic [31:0] redirect_pc1;
  logic        arvalid1, rvalid1, inst_valid1, m1_rvalid;
  logic [31:0] araddr1, rdata1, inst_pc1, inst_data1, m1_rdata;
  // latency-0 instance
  logic        reset0, redirect0, ready0, spur0;
  logic [31:0] redirect_pc0;
  logic        arvalid0, rvalid0, inst_valid0;
  logic [31:0] araddr0, rdata0, inst_pc0, inst_data0;

  item_t q1[$];
  item_t q0[$];
  item_t it1, it0;
  int    n_cmp  = 0;
  int    n_fail = 0;
  int    deliv1 = 0;
  int    deliv0 = 0;
  int    d0;

  function automatic logic [31:0] insn(input logic [31:0] a);
    return {a[23:0], a[31:24]} ^ 32'h0000_0013;
  endfunction

  svc_rv_ifetch #(.XLEN(32), .RESET_PC(32'h100), .IMEM_LATENCY(1), .DEPTH(2)) dut1 (
    .clock(clock), .reset(reset1), .redirect_valid(redirect1), .redirect_pc(redirect_pc1),
    .imem_arvalid(arvalid1), .imem_araddr(araddr1), .imem_rdata(rdata1), .imem_rvalid(rvalid1),
    .inst_valid(inst_valid1), .inst_ready(ready1), .inst_pc(inst_pc1), .inst_data(inst_data1));

  svc_rv_ifetch #(.XLEN(32), .RESET_PC(32'h0), .IMEM_LATENCY(0), .DEPTH(2)) dut0 (
    .clock(clock), .reset(reset0), .redirect_valid(redirect0), .redirect_pc(redirect_pc0),
    .imem_arvalid(arvalid0), .imem_araddr(araddr0), .imem_rdata(rdata0), .imem_rvalid(rvalid0),
    .inst_valid(inst_valid0), .inst_ready(ready0), .inst_pc(inst_pc0), .inst_data(inst_data0));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory models: registered one-cycle response, and combinational response.
  always @(posedge clock) begin
    m1_rvalid <= arvalid1;
    m1_rdata  <= insn(araddr1);
  end
  assign rvalid1 = m1_rvalid | spur1;
  assign rdata1  = m1_rdata;
  assign rvalid0 = arvalid0 | spur0;
  assign rdata0  = spur0 ? 32'hDEAD_BEEF : insn(araddr0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic push1(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) q1.push_back({base + 32'(4 * i), insn(base + 32'(4 * i))});
  endtask

  task automatic push0(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) q0.push_back({base + 32'(4 * i), insn(base + 32'(4 * i))});
  endtask

  // Monitor: every accepted head is compared against the scoreboard front.
  always @(negedge clock) begin
    if (!reset1 && !redirect1 && inst_valid1 && ready1) begin
      deliv1++;
      if (q1.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL dut1_unexpected: got pc %h expected none", inst_pc1);
      end else begin
        it1 = q1.pop_front();
        chk("dut1_pc", inst_pc1, it1.pc);
        chk("dut1_data", inst_data1, it1.data);
      end
    end
  end

  always @(negedge clock) begin
    if (!reset0 && !redirect0 && inst_valid0 && ready0) begin
      deliv0++;
      if (q0.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL dut0_unexpected: got pc %h expected none", inst_pc0);
      end else begin
        it0 = q0.pop_front();
        chk("dut0_pc", inst_pc0, it0.pc);
        chk("dut0_data", inst_data0, it0.data);
      end
    end
  end

  initial begin
    reset1 = 1'b1; redirect1 = 1'b0; ready1 = 1'b0; spur1 = 1'b0; redirect_pc1 = '0;
    reset0 = 1'b1; redirect0 = 1'b0; ready0 = 1'b0; spur0 = 1'b0; redirect_pc0 = '0;

    // Reset state
    tick(); tick();
    mid();
    chk("rst_arvalid", 32'(arvalid1), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid1), 32'd0);
    chk("rst_araddr", araddr1, 32'h100);

    // Streaming from reset with ready high
    push1(32'h100, 16);
    tick(); reset1 = 1'b0; ready1 = 1'b1; d0 = deliv1;
    mid(); chk("s_a0_arvalid", 32'(arvalid1), 32'd1); chk("s_a0_addr", araddr1, 32'h100);
    chk("s_a0_valid", 32'(inst_valid1), 32'd0);
    tick(); mid(); chk("s_a1_addr", araddr1, 32'h104); chk("s_a1_valid", 32'(inst_valid1), 32'd0);
    tick(); mid(); chk("s_a2_addr", araddr1, 32'h108); chk("s_a2_valid", 32'(inst_valid1), 32'd1);
    chk("s_a2_pc", inst_pc1, 32'h100);
    repeat (5) tick();
    tick(); chk("s_delivered", 32'(deliv1 - d0), 32'd6);
    ready1 = 1'b0; reset1 = 1'b1; q1.delete();
    tick();

    // Backpressure: DEPTH requests then stall
    tick(); reset1 = 1'b0; push1(32'h100, 1); d0 = deliv1;
    mid(); chk("bp_b0_arvalid", 32'(arvalid1), 32'd1); chk("bp_b0_addr", araddr1, 32'h100);
    tick(); mid(); chk("bp_b1_arvalid", 32'(arvalid1), 32'd1); chk("bp_b1_addr", araddr1, 32'h104);
    tick(); mid(); chk("bp_b2_arvalid", 32'(arvalid1), 32'd0);
    tick(); mid(); chk("bp_b3_arvalid", 32'(arvalid1), 32'd0); chk("bp_b3_pc", inst_pc1, 32'h100);
    chk("bp_b3_valid", 32'(inst_valid1), 32'd1);
    tick(); mid(); chk("bp_b4_arvalid", 32'(arvalid1), 32'd0);
    tick(); ready1 = 1'b1;
    mid(); chk("bp_b5_arvalid", 32'(arvalid1), 32'd1); chk("bp_b5_addr", araddr1, 32'h108);

    // Redirect with one read in flight and 0x104 buffered
    tick(); chk("bp_delivered", 32'(deliv1 - d0), 32'd1);
    ready1 = 1'b0; redirect1 = 1'b1; redirect_pc1 = 32'h203; q1.delete(); push1(32'h200, 16);
    mid(); chk("rd_arvalid", 32'(arvalid1), 32'd0); chk("rd_head_pc", inst_pc1, 32'h104);
    tick(); redirect1 = 1'b0; ready1 = 1'b1; d0 = deliv1;
    mid(); chk("rd_b7_addr", araddr1, 32'h200); chk("rd_b7_arvalid", 32'(arvalid1), 32'd1);
    chk("rd_b7_valid", 32'(inst_valid1), 32'd0);
    tick(); mid(); chk("rd_b8_valid", 32'(inst_valid1), 32'd0);
    tick(); mid(); chk("rd_b9_pc", inst_pc1, 32'h200);
    repeat (5) tick();

    // Back-to-back redirects
    tick(); chk("rd_delivered", 32'(deliv1 - d0), 32'd6);
    redirect1 = 1'b1; redirect_pc1 = 32'h300; q1.delete();
    mid(); chk("rr_r0_arvalid", 32'(arvalid1), 32'd0);
    tick(); redirect_pc1 = 32'h400; push1(32'h400, 16); d0 = deliv1;
    mid(); chk("rr_r1_arvalid", 32'(arvalid1), 32'd0); chk("rr_r1_valid", 32'(inst_valid1), 32'd0);
    tick(); redirect1 = 1'b0;
    mid(); chk("rr_r2_addr", araddr1, 32'h400); chk("rr_r2_arvalid", 32'(arvalid1), 32'd1);
    repeat (7) tick();

    // PC wrap
    tick(); chk("rr_delivered", 32'(deliv1 - d0), 32'd6);
    redirect1 = 1'b1; redirect_pc1 = 32'hFFFF_FFFC; q1.delete(); push1(32'hFFFF_FFFC, 16); d0 = deliv1;
    mid(); chk("w_w0_arvalid", 32'(arvalid1), 32'd0);
    tick(); redirect1 = 1'b0;
    mid(); chk("w_w1_addr", araddr1, 32'hFFFF_FFFC);
    tick(); mid(); chk("w_w2_addr", araddr1, 32'h0);
    tick(); mid(); chk("w_w3_pc", inst_pc1, 32'hFFFF_FFFC);
    tick(); mid(); chk("w_w4_pc", inst_pc1, 32'h0);
    tick(); tick();

    // Mid-stream reset, then a spurious response with nothing outstanding
    tick(); chk("w_delivered", 32'(deliv1 - d0), 32'd4);
    reset1 = 1'b1; q1.delete();
    tick(); mid();
    chk("mr_valid", 32'(inst_valid1), 32'd0); chk("mr_arvalid", 32'(arvalid1), 32'd0);
    chk("mr_addr", araddr1, 32'h100);
    tick(); reset1 = 1'b0; ready1 = 1'b0; spur1 = 1'b1; push1(32'h100, 1);
    mid(); chk("sp_w9_arvalid", 32'(arvalid1), 32'd1); chk("sp_w9_valid", 32'(inst_valid1), 32'd0);
    tick(); spur1 = 1'b0;
    mid(); chk("sp_w10_valid", 32'(inst_valid1), 32'd0);
    tick(); mid(); chk("sp_w11_valid", 32'(inst_valid1), 32'd1); chk("sp_w11_pc", inst_pc1, 32'h100);
    tick(); ready1 = 1'b1;
    tick(); ready1 = 1'b0; reset1 = 1'b1;
    chk("dut1_left", 32'(q1.size()), 32'd0);

    // Zero-latency instance: spurious responses during reset and while stalled
    spur0 = 1'b1;
    tick(); tick();
    mid(); chk("l0_rst_valid", 32'(inst_valid0), 32'd0); chk("l0_rst_arvalid", 32'(arvalid0), 32'd0);
    push0(32'h0, 6);
    tick(); reset0 = 1'b0; spur0 = 1'b0; d0 = deliv0;
    mid(); chk("l0_c0_arvalid", 32'(arvalid0), 32'd1); chk("l0_c0_addr", araddr0, 32'h0);
    chk("l0_c0_valid", 32'(inst_valid0), 32'd0);
    tick(); mid(); chk("l0_c1_addr", araddr0, 32'h4); chk("l0_c1_valid", 32'(inst_valid0), 32'd1);
    chk("l0_c1_pc", inst_pc0, 32'h0);
    tick(); spur0 = 1'b1;
    mid(); chk("l0_c2_arvalid", 32'(arvalid0), 32'd0);
    tick(); spur0 = 1'b0; ready0 = 1'b1;
    mid(); chk("l0_c3_arvalid", 32'(arvalid0), 32'd1); chk("l0_c3_addr", araddr0, 32'h8);
    repeat (5) tick();
    tick(); chk("l0_delivered", 32'(deliv0 - d0), 32'd6);
    reset0 = 1'b1;
    tick(); reset0 = 1'b0; ready0 = 1'b0;
    mid(); chk("l0_mr_valid", 32'(inst_valid0), 32'd0); chk("l0_mr_arvalid", 32'(arvalid0), 32'd1);
    chk("l0_mr_addr", araddr0, 32'h0);
    tick(); mid(); chk("l0_c11_valid", 32'(inst_valid0), 32'd1); chk("l0_c11_pc", inst_pc0, 32'h0);
    chk("dut0_left", 32'(q0.size()), 32'd0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
